bcd_tick_counter: RTL

Two-digit BCD counter that consumes the divided slow clock produced by the clock-divider stage and drives the two-digit seven-segment display. The divided signal is treated as an asynchronous level: it is synchronised into the system clock domain, and its rising edges become single-cycle count enables. The block never uses the divided signal as a clock. The count steps up or down between configurable decimal bounds and is decoded to active-low segment patterns.

---
 rtl/bcd_tick_counter_pkg.sv | 29 ++
 rtl/bcd_tick_counter_seg7_decoder.sv | 26 ++
 rtl/bcd_tick_counter.sv | 104 ++++++++++
 3 files changed

// File: rtl/bcd_tick_counter_pkg.sv
// Shared widths, seven-segment patterns and a decimal-to-BCD helper
// for the two-digit tick counter.
package bcd_tick_counter_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    // Active-low segments, bit0 = a ... bit6 = g
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    function automatic logic [2*DIGIT_W-1:0] to_bcd(input int unsigned value);
        logic [DIGIT_W-1:0] tens_digit;
        logic [DIGIT_W-1:0] ones_digit;
        tens_digit = DIGIT_W'(value / 10);
        ones_digit = DIGIT_W'(value % 10);
        return {tens_digit, ones_digit};
    endfunction

endpackage

// File: rtl/bcd_tick_counter_seg7_decoder.sv
// BCD digit to active-low seven-segment decode; non-decimal nibbles blank.
module seg7_decoder
    import bcd_tick_counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (digit)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of a synchronised
// slow tick level, with wrap pulse and seven-segment outputs.
module bcd_tick_counter
    import bcd_tick_counter_pkg::*;
#(
    parameter int unsigned COUNT_MIN   = 0,
    parameter int unsigned COUNT_MAX   = 99,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick_in,
    input  logic               run,
    input  logic               up,
    input  logic               clear,
    output logic [DIGIT_W-1:0] ones,
    output logic [DIGIT_W-1:0] tens,
    output logic [SEG_W-1:0]   hex0,
    output logic [SEG_W-1:0]   hex1,
    output logic               wrap
);

    localparam logic [2*DIGIT_W-1:0] MIN_BCD = to_bcd(COUNT_MIN);
    localparam logic [2*DIGIT_W-1:0] MAX_BCD = to_bcd(COUNT_MAX);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [DIGIT_W-1:0]     ones_q, ones_d;
    logic [DIGIT_W-1:0]     tens_q, tens_d;
    logic                   wrap_q, wrap_d;
    logic                   step;
    logic [2*DIGIT_W-1:0]   count;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], tick_in};
    assign prev_d = sync_q[SYNC_STAGES-1];
    assign step   = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign count  = {tens_q, ones_q};

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        if (clear) begin
            ones_d = MIN_BCD[DIGIT_W-1:0];
            tens_d = MIN_BCD[2*DIGIT_W-1:DIGIT_W];
        end else if (step && run) begin
            if (up) begin
                if (count == MAX_BCD) begin
                    ones_d = MIN_BCD[DIGIT_W-1:0];
                    tens_d = MIN_BCD[2*DIGIT_W-1:DIGIT_W];
                    wrap_d = 1'b1;
                end else if (ones_q == 4'd9) begin
                    ones_d = '0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (count == MIN_BCD) begin
                    ones_d = MAX_BCD[DIGIT_W-1:0];
                    tens_d = MAX_BCD[2*DIGIT_W-1:DIGIT_W];
                    wrap_d = 1'b1;
                end else if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    // Sync chain resets high so a tick already high at release is not an edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            ones_q <= MIN_BCD[DIGIT_W-1:0];
            tens_q <= MIN_BCD[2*DIGIT_W-1:DIGIT_W];
            wrap_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            ones_q <= ones_d;
            tens_q <= tens_d;
            wrap_q <= wrap_d;
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;
    assign wrap = wrap_q;

    seg7_decoder u_dec_ones (
        .digit    (ones_q),
        .segments (hex0)
    );

    seg7_decoder u_dec_tens (
        .digit    (tens_q),
        .segments (hex1)
    );

endmodule
